// File: rtl/lib_arbiter_pkg.sv
// Shared types for the pixel arbiter hierarchy and its event encoder.
// Holds the default event word layout and the encoder FSM states.
package lib_arbiter_pkg;

  localparam int ENC_ROW_W = 4;
  localparam int ENC_COL_W = 4;
  localparam int ENC_TS_W  = 16;

  typedef struct packed {
    logic [ENC_TS_W-1:0]  ts;
    logic [ENC_ROW_W-1:0] row;
    logic [ENC_COL_W-1:0] col;
  } evt_word_t;

  // ST_ prefix keeps the state names clear of the HOLDOFF parameter in the encoder.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RELEASE,
    ST_HOLDOFF
  } enc_state_t;

endpackage

// File: rtl/evt_fifo_fwft.sv
// First-word-fall-through event FIFO: the head word is visible on data the cycle after it is written.
// A push while full is accepted only when a pop frees a slot at the same edge.
module evt_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pixel_event_encoder.sv
// Timestamps each arbiter grant, buffers {ts, row, col} in a FWFT FIFO and pulses grp_release_o.
// state      | meaning
// ST_IDLE    | waiting for active_i; captures unless the FIFO is full (stall)
// ST_RELEASE | one-cycle grp_release_o pulse, loads the holdoff down-counter
// ST_HOLDOFF | lets the arbiter update its grant; exits when the counter reads 0
module pixel_event_encoder
  import lib_arbiter_pkg::*;
#(
  parameter int ROW_W      = ENC_ROW_W,
  parameter int COL_W      = ENC_COL_W,
  parameter int TS_W       = ENC_TS_W,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLDOFF    = 2,
  localparam int EVT_W     = TS_W + ROW_W + COL_W,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             active_i,
  input  logic [ROW_W-1:0] row_addr_i,
  input  logic [COL_W-1:0] col_addr_i,
  output logic             grp_release_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [EVT_W-1:0] evt_data_o,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             stall_o
);

  localparam int HO_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam int HO_W    = (HO_LOAD > 0) ? $clog2(HO_LOAD + 1) : 1;

  enc_state_t      state;
  enc_state_t      state_nxt;
  logic [TS_W-1:0] ts;
  logic [HO_W-1:0] ho_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            full_eff;
  logic            capture;

  assign evt_valid_o = !fifo_empty;
  assign pop         = evt_valid_o && evt_ready_i;
  // A pop at the same edge frees the slot the capture needs.
  assign full_eff    = fifo_full && !pop;

  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    grp_release_o = 1'b0;
    stall_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (active_i) begin
          if (full_eff) begin
            stall_o = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        grp_release_o = 1'b1;
        state_nxt     = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (ho_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ts     <= '0;
      ho_cnt <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (state == ST_RELEASE)                  ho_cnt <= HO_W'(HO_LOAD);
      else if (state == ST_HOLDOFF && ho_cnt != '0) ho_cnt <= ho_cnt - 1'b1;
    end
  end

  evt_fifo_fwft #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (reset_i),
    .push      (capture),
    .push_data ({ts, row_addr_i, col_addr_i}),
    .pop       (pop),
    .data      (evt_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

endmodule

// File: tb/tb_pixel_event_encoder.sv
// Directed bench for pixel_event_encoder: a default instance plus a TS_W=4, HOLDOFF=0 instance for wrap.
module tb_pixel_event_encoder;
  import lib_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        active = 1'b0;
  logic [3:0]  row = '0;
  logic [3:0]  col = '0;
  logic        ready = 1'b0;
  logic        release_o;
  logic        valid;
  logic [23:0] data;
  logic [3:0]  level;
  logic        stall;

  logic        b_active = 1'b0;
  logic [3:0]  b_row = '0;
  logic [3:0]  b_col = '0;
  logic        b_ready = 1'b1;
  logic        b_release;
  logic        b_valid;
  logic [11:0] b_data;
  logic [3:0]  b_level;
  logic        b_stall;

  logic [15:0] ts_m;
  evt_word_t   exp_q[$];
  evt_word_t   exp_w;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Reference free-running timestamp, shared by both instances (same reset).
  always @(posedge clk) begin
    if (!reset_i) ts_m <= '0;
    else          ts_m <= ts_m + 16'd1;
  end

  pixel_event_encoder dut (
    .clk_i(clk), .reset_i(reset_i), .active_i(active), .row_addr_i(row), .col_addr_i(col),
    .grp_release_o(release_o), .evt_valid_o(valid), .evt_ready_i(ready), .evt_data_o(data),
    .fifo_level_o(level), .stall_o(stall)
  );

  pixel_event_encoder #(.TS_W(4), .HOLDOFF(0)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .active_i(b_active), .row_addr_i(b_row), .col_addr_i(b_col),
    .grp_release_o(b_release), .evt_valid_o(b_valid), .evt_ready_i(b_ready), .evt_data_o(b_data),
    .fifo_level_o(b_level), .stall_o(b_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; active = 1'b1; row = 4'h3; col = 4'h5; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (release_o !== 1'b0) begin errors++; $display("FAIL reset_release: got %b expected 0", release_o); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    end
    reset_i = 1'b1; row = 4'h1; col = 4'h2;
    step();
    checks++; if (release_o !== 1'b1) begin errors++; $display("FAIL reset_first_release: got %b expected 1", release_o); end
    checks++; if (data !== {16'd0, 4'h1, 4'h2}) begin errors++; $display("FAIL reset_first_ts: got %h expected %h", data, {16'd0, 4'h1, 4'h2}); end
    active = 1'b0; ready = 1'b1;
    step();
    checks++; if (level !== 4'd0 || valid !== 1'b0) begin errors++; $display("FAIL reset_first_pop: got level %0d valid %b expected 0 0", level, valid); end
    repeat (2) step();
  endtask

  task automatic test_timestamp_wrap();
    int n;
    n = 0;
    while (ts_m[3:0] != 4'hf && n < 40) begin step(); n++; end
    checks++; if (ts_m[3:0] != 4'hf) begin errors++; $display("FAIL wrap_timeout: got ts %0d expected 15", ts_m[3:0]); end
    b_active = 1'b1; b_row = 4'h1; b_col = 4'h1;
    step();
    checks++; if (b_release !== 1'b1 || b_data !== {4'd15, 4'h1, 4'h1}) begin errors++; $display("FAIL wrap_cap15: got rel %b data %h expected 1 %h", b_release, b_data, {4'd15, 4'h1, 4'h1}); end
    b_row = 4'h2; b_col = 4'h2;
    step();
    checks++; if (b_release !== 1'b0 || b_level !== 4'd0) begin errors++; $display("FAIL wrap_idle: got rel %b level %0d expected 0 0", b_release, b_level); end
    step();
    checks++; if (b_release !== 1'b1 || b_data !== {4'd1, 4'h2, 4'h2} || b_level !== 4'd1) begin errors++; $display("FAIL wrap_cap1: got rel %b data %h level %0d expected 1 %h 1", b_release, b_data, b_level, {4'd1, 4'h2, 4'h2}); end
    b_active = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_single_grant();
    logic [15:0] ts1, ts2;
    ready = 1'b1; active = 1'b1; row = 4'h3; col = 4'h5;
    ts1 = ts_m;
    step();
    checks++; if (release_o !== 1'b1) begin errors++; $display("FAIL single_release: got %b expected 1", release_o); end
    checks++; if (valid !== 1'b1 || data !== {ts1, 4'h3, 4'h5}) begin errors++; $display("FAIL single_data: got valid %b data %h expected 1 %h", valid, data, {ts1, 4'h3, 4'h5}); end
    row = 4'h4; col = 4'h6;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ts2 = ts_m + 16'd1;
      step();
      checks++; if (release_o !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL single_spacing%0d: got rel %b level %0d expected 0 0", i, release_o, level); end
    end
    step();
    checks++; if (release_o !== 1'b1 || data !== {ts2, 4'h4, 4'h6}) begin errors++; $display("FAIL single_second: got rel %b data %h expected 1 %h", release_o, data, {ts2, 4'h4, 4'h6}); end
    active = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    int rel_cnt;
    ready = 1'b0; active = 1'b1;
    for (int k = 0; k < 8; k++) begin
      row = 4'(k); col = 4'(k);
      exp_w.ts = ts_m; exp_w.row = 4'(k); exp_w.col = 4'(k);
      exp_q.push_back(exp_w);
      step();
      checks++; if (release_o !== 1'b1) begin errors++; $display("FAIL bp_release%0d: got %b expected 1", k, release_o); end
      repeat (3) step();
    end
    row = 4'h8; col = 4'h8;
    #1;
    checks++; if (level !== 4'd8 || stall !== 1'b1) begin errors++; $display("FAIL bp_full: got level %0d stall %b expected 8 1", level, stall); end
    rel_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      if (j == 3) begin row = 4'h9; col = 4'h9; end
      step();
      if (release_o === 1'b1) rel_cnt++;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bp_stall%0d: got %b expected 1", j, stall); end
    end
    checks++; if (rel_cnt != 0 || level !== 4'd8) begin errors++; $display("FAIL bp_hold: got releases %0d level %0d expected 0 8", rel_cnt, level); end
    checks++; if (data !== exp_q[0]) begin errors++; $display("FAIL bp_head: got %h expected %h", data, exp_q[0]); end
  endtask

  task automatic test_push_pop_full();
    ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ppf_stall: got %b expected 0", stall); end
    checks++; if (data !== exp_q[0]) begin errors++; $display("FAIL ppf_pop_head: got %h expected %h", data, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_w.ts = ts_m; exp_w.row = 4'h9; exp_w.col = 4'h9;
    exp_q.push_back(exp_w);
    step();
    ready = 1'b0; active = 1'b0;
    checks++; if (release_o !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL ppf_level: got rel %b level %0d expected 1 8", release_o, level); end
    checks++; if (data !== exp_q[0]) begin errors++; $display("FAIL ppf_new_head: got %h expected %h", data, exp_q[0]); end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (valid !== 1'b1 || data !== exp_w) begin errors++; $display("FAIL ppf_drain%0d: got valid %b data %h expected 1 %h", i, valid, data, exp_w); end
      step();
    end
    checks++; if (valid !== 1'b0 || data !== 24'h0 || level !== 4'd0) begin errors++; $display("FAIL ppf_empty: got valid %b data %h level %0d expected 0 0 0", valid, data, level); end
  endtask

  task automatic test_reset_mid_holdoff();
    ready = 1'b0; active = 1'b1;
    for (int k = 0; k < 3; k++) begin
      row = 4'(k + 1); col = 4'(k + 1);
      step();
      if (k < 2) repeat (3) step();
    end
    step();
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL rmh_pre_level: got %0d expected 3", level); end
    reset_i = 1'b0;
    step();
    checks++; if (level !== 4'd0 || valid !== 1'b0 || release_o !== 1'b0 || data !== 24'h0) begin errors++; $display("FAIL rmh_cleared: got level %0d valid %b rel %b data %h expected 0 0 0 0", level, valid, release_o, data); end
    reset_i = 1'b1; row = 4'h2; col = 4'h7;
    step();
    checks++; if (release_o !== 1'b1 || level !== 4'd1 || data !== {16'd0, 4'h2, 4'h7}) begin errors++; $display("FAIL rmh_resume: got rel %b level %0d data %h expected 1 1 %h", release_o, level, data, {16'd0, 4'h2, 4'h7}); end
    active = 1'b0; ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_timestamp_wrap();
    test_single_grant();
    test_backpressure();
    test_push_pop_full();
    test_reset_mid_holdoff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_event_encoder.md
Name: pixel_event_encoder

Overview:
- Downstream consumer of the level-1 pixel group array: takes the granted pixel's row/column address and the hierarchy's active flag.
- Timestamps each grant, packs it into an event word and buffers it in a FIFO. The FIFO drains through a valid/ready output port.
- Issues the one-cycle grp_release pulse that lets the arbiter advance to the next request.
- Applies backpressure: no release while the FIFO is full, so the current grant is held and no event is lost.

Parameters:
- ROW_W, 4, width of the row address (hierarchical y address, level-concatenated)
- COL_W, 4, width of the column address
- TS_W, 16, timestamp counter width
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, ≥2
- HOLDOFF, 2, cycles to wait after a release before sampling the address again (covers arbiter grant update)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active low
- active_i  in  1  high while the hierarchy holds a valid grant
- row_addr_i  in  ROW_W  row address of the granted pixel
- col_addr_i  in  COL_W  column address of the granted pixel
- grp_release_o  out  1  one-cycle pulse: current event captured, arbiter may advance
- evt_valid_o  out  1  FIFO head valid
- evt_ready_i  in  1  downstream accepts the head word
- evt_data_o  out  TS_W+ROW_W+COL_W  packed event {ts, row, col}, MSB first
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- stall_o  out  1  high when active_i=1 in IDLE and the FIFO is full

Behaviour:
- Reset (reset_i=0 at a clk_i edge):
  - State goes to IDLE; timestamp is 0; FIFO pointers and level are 0.
  - grp_release_o=0, evt_valid_o=0, evt_data_o=0, stall_o=0.
  - Reset mid-operation discards all buffered events and any pending release.
- Timestamp:
  - Free-running counter, increments every cycle out of reset.
  - Wraps from 2^TS_W-1 to 0 with no marker.
  - The word captures the counter value of the capture cycle.
- FSM states: IDLE, RELEASE, HOLDOFF.
  - IDLE:
    - If active_i=1 and the FIFO is not full: write {ts, row_addr_i, col_addr_i} at this edge, go to RELEASE.
    - If active_i=1 and the FIFO is full: stay in IDLE, stall_o=1 (combinational), no write.
    - If active_i=0: stay in IDLE.
  - RELEASE: grp_release_o=1 for exactly this cycle; go to HOLDOFF with the counter loaded to HOLDOFF-1. If HOLDOFF=0, go directly to IDLE.
  - HOLDOFF: decrement the counter; go to IDLE on the cycle the counter reads 0. active_i and the addresses are ignored in this state.
- Latency:
  - Capture edge at cycle n.
  - grp_release_o high in cycle n+1.
  - Back in IDLE at cycle n+2+HOLDOFF.
  - Minimum grant-to-grant spacing is 2+HOLDOFF cycles.
- FIFO:
  - First-word-fall-through: the word written at edge n is visible on evt_data_o with evt_valid_o=1 in cycle n+1 if the FIFO was empty.
  - Pop when evt_valid_o && evt_ready_i.
  - Simultaneous push and pop: level unchanged, both take effect, and a push while full is permitted in that case.
  - The full check in IDLE uses level==FIFO_DEPTH && !(evt_valid_o && evt_ready_i).
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_data_o holds its value while evt_valid_o=1 and evt_ready_i=0.
  - evt_data_o equals 0 when the FIFO is empty.
- active_i dropping in RELEASE or HOLDOFF has no effect; the event is already captured.

Decomposition:
- lib_arbiter_pkg gains:
  - ENC_ROW_W, ENC_COL_W, ENC_TS_W constants
  - packed struct typedef evt_word_t {ts, row, col}
  - enum typedef enc_state_t {IDLE, RELEASE, HOLDOFF}
- One sub-module, evt_fifo_fwft: parameterised width and depth, synchronous active-low reset, push/pop/full/empty/level.
- The FSM and timestamp counter stay in the top block.

Test Plan:
- Reset: hold reset_i=0 for 3 cycles with active_i=1. Required: grp_release_o=0, evt_valid_o=0, fifo_level_o=0; after release, timestamp 0 is in the first cycle.
- Single grant: active_i=1, row=3, col=5, HOLDOFF=2, ready=1. Required: one grp_release_o pulse 1 cycle after capture; evt_data_o={ts_capture,4'h3,4'h5} valid the next cycle; next capture no earlier than 4 cycles after the first.
- Backpressure: evt_ready_i=0, active_i held high, addresses stepped 0..9. Required: exactly 8 events stored, fifo_level_o=8, stall_o=1, no further grp_release_o. Then raise ready for 1 cycle: one pop, then one capture and release.
- Simultaneous push/pop at full: level=8 with ready=1 during an IDLE capture. Required: level stays 8, ordering preserved.
- Timestamp wrap with TS_W=4: capture at ts=15, then the next event captures ts=1 (15+2 wrap, HOLDOFF=0).
- Reset mid-HOLDOFF with 3 events buffered. Required: next cycle level=0, evt_valid_o=0, state IDLE, and capture resumes when active_i=1.
